adder_bist_checker: RTL and testbench
=====================================

Name: adder_bist_checker

Overview:
- Synthesizable built-in self-test engine for combinational adder blocks such as the team's full_adder.
- Drives an exhaustive, ordered input sweep into the adder under test and checks every sum/carry response against a golden a+b+cin model.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits next to the adder in the Lab3 datapath as its on-chip self-check, replacing manual waveform inspection.

Parameters:
- WIDTH, 1, operand width of the adder under test (1 = single full_adder).
- SETTLE, 1, clock cycles each vector is held before its response is sampled (minimum 1).
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a sweep when seen high in IDLE or DONE.
- dut_a  output  WIDTH  operand a to the adder under test.
- dut_b  output  WIDTH  operand b to the adder under test.
- dut_cin  output  1  carry-in to the adder under test.
- dut_sum  input  WIDTH  sum returned by the adder under test.
- dut_cout  input  1  carry-out returned by the adder under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  sweep complete; held until the next start.
- pass  output  1  valid when done: 1 if no mismatches occurred.
- err_count  output  ERR_W  number of mismatching vectors, saturating.
- fail_valid  output  1  first_fail holds a captured vector.
- first_fail  output  2*WIDTH+1  {a,b,cin} of the first mismatching vector.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n. Reset forces the FSM to IDLE and all outputs, vector counter V and settle counter to 0.
- Vector counter V (2*WIDTH+1 bits) maps to the adder inputs as {dut_a, dut_b, dut_cin} = V, with cin = V[0].
- dut_a, dut_b and dut_cin are registered directly from V and the FSM state.
- Sweep order is V = 0 up to 2^(2*WIDTH+1)-1. For WIDTH=1 this is abc = 000, 001, …, 111.
- Golden model: exp = dut_a + dut_b + dut_cin, computed at WIDTH+1 bits. A mismatch is {dut_cout, dut_sum} != exp; X/Z inputs count as a mismatch in simulation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - dut_* = 0, busy = 0.
  - start=1 → clear err_count, fail_valid, first_fail, done and pass; set V=0 and settle counter=0; go to RUN.
- RUN:
  - busy = 1; dut_* = V.
  - Each cycle the settle counter increments.
  - On the edge where the settle counter equals SETTLE-1, the current dut_sum/dut_cout are compared and the settle counter returns to 0. On that edge:
    - Mismatch: err_count increments, saturating at 2^ERR_W-1. If fail_valid=0, first_fail is set to V and fail_valid to 1.
    - If V is at its maximum, go to DONE. Otherwise V increments.
  - Each vector is held exactly SETTLE cycles. A sweep occupies 2^(2*WIDTH+1)*SETTLE cycles in RUN.
- DONE:
  - busy = 0, done = 1, pass = (err_count == 0); dut_* return to 0.
  - Results hold until start=1, which behaves as in IDLE: done and pass clear on the next edge and the sweep restarts at V=0.
- start while in RUN is ignored; no restart and no effect on counters.
- Reset mid-sweep: immediate abort to IDLE with all results cleared. No partial result is retained.
- A mismatch on the final vector is counted before DONE is entered, so pass reflects it in the first DONE cycle.
- SETTLE=1: the compare happens in the same cycle the vector is first driven. The adder under test must be purely combinational.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-clock → busy, done, pass, err_count, fail_valid and dut_* go to 0 asynchronously.
- Golden sweep: WIDTH=1, SETTLE=1, correct full_adder connected, 1-cycle start pulse → busy for 8 cycles; dut_{a,b,cin} step 000→111 one per cycle; then done=1, pass=1, err_count=0, fail_valid=0.
- Carry-out stuck-at-0: tie dut_cout to 0 → mismatches at 011, 101, 110 and 111; err_count=4, first_fail=3'b011, fail_valid=1, pass=0.
- Settle timing: SETTLE=3 → each vector held 3 cycles, busy for 24 cycles, sample taken on the third cycle of each vector; golden adder gives pass=1.
- Reset and start handling: reset during vector 4, then restart → sweep resumes from V=0 with err_count=0. start held high throughout RUN → no restart. start pulse in DONE → done=0 next cycle and a fresh sweep begins.
- Saturation: WIDTH=2, ERR_W=2, dut_sum stuck at 0 → 32 vectors with many mismatches; err_count saturates at 3 with no wrap; first_fail=5'b00001.

Source files
------------

// File: rtl/adder_bist_checker.sv
// Built-in self-test engine for a combinational adder: sweeps every {a,b,cin}
// combination in order and checks each sum/carry response against a+b+cin.
module adder_bist_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_cin,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 fail_valid,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW         = 2 * WIDTH + 1;
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int SW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_EFF - 1);
  localparam logic [VW-1:0]    V_MAX       = '1;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [VW-1:0]     v_q, v_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [VW-1:0]     dut_vec_q, dut_vec_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              fail_valid_q, fail_valid_d;
  logic [VW-1:0]     first_fail_q, first_fail_d;

  logic [WIDTH:0]    exp_sum;
  logic              mismatch;
  logic              sample;

  // Golden model works on the operands actually presented to the adder,
  // so the compare always pairs a response with the vector that caused it.
  always_comb begin
    exp_sum  = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
    mismatch = ({dut_cout, dut_sum} !== exp_sum);
    sample   = (state_q == ST_RUN) && (settle_q == SETTLE_LAST);
  end

  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    settle_d     = settle_q;
    dut_vec_d    = dut_vec_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          v_d          = '0;
          settle_d     = '0;
          dut_vec_d    = '0;
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
        end
      end

      ST_RUN: begin
        if (sample) begin
          settle_d = '0;
          if (mismatch) begin
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              first_fail_d = v_q;
            end
          end
          if (v_q == V_MAX) begin
            state_d   = ST_DONE;
            dut_vec_d = '0;
          end else begin
            v_d       = v_q + VW'(1);
            dut_vec_d = v_q + VW'(1);
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        dut_vec_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      v_q          <= '0;
      settle_q     <= '0;
      dut_vec_q    <= '0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      settle_q     <= settle_d;
      dut_vec_q    <= dut_vec_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  // dut_vec_q tracks V while running and is zero otherwise.
  assign dut_a      = dut_vec_q[VW-1 -: WIDTH];
  assign dut_b      = dut_vec_q[WIDTH:1];
  assign dut_cin    = dut_vec_q[0];

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = (state_q == ST_DONE) && (err_count_q == '0);
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: three engines (1-bit fast, 1-bit slow settle,
// 2-bit narrow counter) against golden and faulty adders, scoreboard checked.
module tb_adder_bist_checker;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- u1: WIDTH=1 SETTLE=1 ----------------
  logic       u1_start, u1_mode;
  logic       u1_a, u1_b, u1_cin, u1_sum, u1_cout;
  logic       u1_busy, u1_done, u1_pass, u1_fv;
  logic [7:0] u1_err;
  logic [2:0] u1_ff;
  logic [1:0] u1_gold;

  assign u1_gold = {1'b0, u1_a} + {1'b0, u1_b} + {1'b0, u1_cin};
  assign u1_sum  = u1_gold[0];
  assign u1_cout = u1_mode ? 1'b0 : u1_gold[1];

  adder_bist_checker #(.WIDTH(1), .SETTLE(1), .ERR_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(u1_start),
    .dut_a(u1_a), .dut_b(u1_b), .dut_cin(u1_cin),
    .dut_sum(u1_sum), .dut_cout(u1_cout),
    .busy(u1_busy), .done(u1_done), .pass(u1_pass),
    .err_count(u1_err), .fail_valid(u1_fv), .first_fail(u1_ff)
  );

  // ---------------- u3: WIDTH=1 SETTLE=3 ----------------
  logic       u3_start;
  logic       u3_a, u3_b, u3_cin, u3_sum, u3_cout;
  logic       u3_busy, u3_done, u3_pass, u3_fv;
  logic [7:0] u3_err;
  logic [2:0] u3_ff;
  logic [1:0] u3_gold;

  assign u3_gold = {1'b0, u3_a} + {1'b0, u3_b} + {1'b0, u3_cin};
  assign u3_sum  = u3_gold[0];
  assign u3_cout = u3_gold[1];

  adder_bist_checker #(.WIDTH(1), .SETTLE(3), .ERR_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .start(u3_start),
    .dut_a(u3_a), .dut_b(u3_b), .dut_cin(u3_cin),
    .dut_sum(u3_sum), .dut_cout(u3_cout),
    .busy(u3_busy), .done(u3_done), .pass(u3_pass),
    .err_count(u3_err), .fail_valid(u3_fv), .first_fail(u3_ff)
  );

  // ---------------- u2: WIDTH=2 ERR_W=2, sum stuck at 0 ----------------
  logic       u2_start;
  logic [1:0] u2_a, u2_b, u2_sum;
  logic       u2_cin, u2_cout;
  logic       u2_busy, u2_done, u2_pass, u2_fv;
  logic [1:0] u2_err;
  logic [4:0] u2_ff;
  logic [2:0] u2_gold;

  assign u2_gold = {1'b0, u2_a} + {1'b0, u2_b} + {2'b00, u2_cin};
  assign u2_sum  = 2'b00;
  assign u2_cout = u2_gold[2];

  adder_bist_checker #(.WIDTH(2), .SETTLE(1), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(u2_start),
    .dut_a(u2_a), .dut_b(u2_b), .dut_cin(u2_cin),
    .dut_sum(u2_sum), .dut_cout(u2_cout),
    .busy(u2_busy), .done(u2_done), .pass(u2_pass),
    .err_count(u2_err), .fail_valid(u2_fv), .first_fail(u2_ff)
  );

  // ---------------- scoreboard ----------------
  logic [2:0]  vec1_q[$];
  logic [15:0] res1_q[$];
  int          len1_q[$];
  logic [2:0]  vec3_q[$];
  logic [15:0] res3_q[$];
  int          len3_q[$];
  logic [15:0] res2_q[$];
  int          len2_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=unexpected expected=none at %0t", name, $time);
  endtask

  function automatic logic [15:0] pk1(input logic p, input logic [7:0] e,
                                      input logic fv, input logic [2:0] ff);
    return {3'b000, p, e, fv, ff};
  endfunction

  function automatic logic [15:0] pk2(input logic p, input logic [1:0] e,
                                      input logic fv, input logic [4:0] ff);
    return {7'b0000000, p, e, fv, ff};
  endfunction

  task automatic push_sweep1(input logic p, input logic [7:0] e,
                             input logic fv, input logic [2:0] ff);
    for (int v = 0; v < 8; v++) vec1_q.push_back(3'(v));
    res1_q.push_back(pk1(p, e, fv, ff));
    len1_q.push_back(8);
  endtask

  // ---------------- monitors ----------------
  int   cnt1, cnt3, cnt2;
  logic dprev1, dprev3, dprev2;

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt1 = 0; cnt3 = 0; cnt2 = 0;
      dprev1 = 1'b0; dprev3 = 1'b0; dprev2 = 1'b0;
    end else begin
      // u1: vector stream while busy, result on done rising
      if (u1_busy) begin
        cnt1++;
        if (vec1_q.size() == 0) miss("u1_vector");
        else chk("u1_vector", 32'({u1_a, u1_b, u1_cin}), 32'(vec1_q.pop_front()));
      end else begin
        if (u1_done && !dprev1) begin
          if (res1_q.size() == 0 || len1_q.size() == 0) miss("u1_result");
          else begin
            chk("u1_result", 32'(pk1(u1_pass, u1_err, u1_fv, u1_ff)), 32'(res1_q.pop_front()));
            chk("u1_busy_len", 32'(cnt1), 32'(len1_q.pop_front()));
          end
        end
        cnt1 = 0;
      end
      dprev1 = u1_done;

      if (u3_busy) begin
        cnt3++;
        if (vec3_q.size() == 0) miss("u3_vector");
        else chk("u3_vector", 32'({u3_a, u3_b, u3_cin}), 32'(vec3_q.pop_front()));
      end else begin
        if (u3_done && !dprev3) begin
          if (res3_q.size() == 0 || len3_q.size() == 0) miss("u3_result");
          else begin
            chk("u3_result", 32'(pk1(u3_pass, u3_err, u3_fv, u3_ff)), 32'(res3_q.pop_front()));
            chk("u3_busy_len", 32'(cnt3), 32'(len3_q.pop_front()));
          end
        end
        cnt3 = 0;
      end
      dprev3 = u3_done;

      if (u2_busy) begin
        cnt2++;
      end else begin
        if (u2_done && !dprev2) begin
          if (res2_q.size() == 0 || len2_q.size() == 0) miss("u2_result");
          else begin
            chk("u2_result", 32'(pk2(u2_pass, u2_err, u2_fv, u2_ff)), 32'(res2_q.pop_front()));
            chk("u2_busy_len", 32'(cnt2), 32'(len2_q.pop_front()));
          end
        end
        cnt2 = 0;
      end
      dprev2 = u2_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int which);
    @(posedge clk);
    #1;
    case (which)
      1: u1_start = 1'b1;
      3: u3_start = 1'b1;
      default: u2_start = 1'b1;
    endcase
    @(posedge clk);
    #1;
    u1_start = 1'b0;
    u3_start = 1'b0;
    u2_start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget);
    int   n;
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        1: d = u1_done;
        3: d = u3_done;
        default: d = u2_done;
      endcase
    end
    if (!d) miss($sformatf("u%0d_done_timeout", which));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic hit;
    rst_n    = 1'b0;
    u1_start = 1'b0;
    u3_start = 1'b0;
    u2_start = 1'b0;
    u1_mode  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_u1_busy", 32'(u1_busy), 32'd0);
    chk("rst_u1_done", 32'(u1_done), 32'd0);
    chk("rst_u1_pass", 32'(u1_pass), 32'd0);
    chk("rst_u1_err", 32'(u1_err), 32'd0);
    chk("rst_u1_fv", 32'(u1_fv), 32'd0);
    chk("rst_u1_vec", 32'({u1_a, u1_b, u1_cin}), 32'd0);
    chk("rst_u2_outs", 32'({u2_busy, u2_done, u2_pass, u2_err, u2_fv, u2_ff, u2_a, u2_b, u2_cin}), 32'd0);
    rst_n = 1'b1;

    // golden full adder: all 8 vectors match
    u1_mode = 1'b0;
    push_sweep1(1'b1, 8'd0, 1'b0, 3'b000);
    pulse_start(1);
    wait_done(1, 40);

    // carry-out stuck at 0, restarted straight from DONE
    u1_mode = 1'b1;
    push_sweep1(1'b0, 8'd4, 1'b1, 3'b011);
    pulse_start(1);
    chk("restart_done_clear", 32'(u1_done), 32'd0);
    chk("restart_busy", 32'(u1_busy), 32'd1);
    chk("restart_pass_clear", 32'(u1_pass), 32'd0);
    chk("restart_err_clear", 32'(u1_err), 32'd0);
    chk("restart_fv_clear", 32'(u1_fv), 32'd0);
    wait_done(1, 40);

    // start held high across the whole run must not restart the sweep
    u1_mode = 1'b0;
    push_sweep1(1'b1, 8'd0, 1'b0, 3'b000);
    @(posedge clk);
    #1 u1_start = 1'b1;
    repeat (8) @(posedge clk);
    #1 u1_start = 1'b0;
    wait_done(1, 40);

    // abort during vector 4 with a failure already recorded
    u1_mode = 1'b1;
    for (int v = 0; v < 5; v++) vec1_q.push_back(3'(v));
    pulse_start(1);
    n = 0;
    hit = 1'b0;
    while (!hit && n < 20) begin
      @(negedge clk);
      n++;
      hit = u1_busy && ({u1_a, u1_b, u1_cin} == 3'd4);
    end
    if (!hit) miss("abort_reach_v4_timeout");
    #1;
    chk("pre_abort_err", 32'(u1_err), 32'd1);
    chk("pre_abort_fv", 32'(u1_fv), 32'd1);
    chk("pre_abort_ff", 32'(u1_ff), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(u1_busy), 32'd0);
    chk("abort_done", 32'(u1_done), 32'd0);
    chk("abort_err", 32'(u1_err), 32'd0);
    chk("abort_fail", 32'({u1_fv, u1_ff}), 32'd0);
    chk("abort_vec", 32'({u1_a, u1_b, u1_cin}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    push_sweep1(1'b0, 8'd4, 1'b1, 3'b011);
    pulse_start(1);
    chk("post_abort_err", 32'(u1_err), 32'd0);
    chk("post_abort_vec", 32'({u1_a, u1_b, u1_cin}), 32'd0);
    wait_done(1, 40);

    // SETTLE=3: every vector held for three cycles
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 3; k++) vec3_q.push_back(3'(v));
    end
    res3_q.push_back(pk1(1'b1, 8'd0, 1'b0, 3'b000));
    len3_q.push_back(24);
    pulse_start(3);
    wait_done(3, 100);

    // WIDTH=2, 2-bit counter saturates at 3; first failure is a=0 b=0 cin=1
    res2_q.push_back(pk2(1'b0, 2'd3, 1'b1, 5'b00001));
    len2_q.push_back(32);
    pulse_start(2);
    wait_done(2, 100);

    repeat (3) @(negedge clk);
    #1;
    chk("u1_done_held", 32'({u1_done, u1_pass}), 32'b10);
    chk("scoreboard_drained",
        32'(vec1_q.size() + res1_q.size() + len1_q.size() + vec3_q.size() +
            res3_q.size() + len3_q.size() + res2_q.size() + len2_q.size()),
        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
